// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32I funct3 encodings for loads and stores
//   - FSM state type
//   - legality helper used in the accept cycle
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_RESP,
    RMW_MERGE,
    DONE
  } lsu_state_t;

  // True when the request must be rejected: an encoding that does not exist
  // for its direction, or an access not aligned to its own size.
  function automatic logic req_illegal(input logic       write,
                                       input logic [2:0] funct3,
                                       input logic [1:0] offset);
    logic bad_f3;
    logic misaligned;
    if (write) bad_f3 = (funct3 > F3_W);
    else       bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned = ((funct3[1:0] == 2'b01) && offset[0]) ||
                 ((funct3[1:0] == 2'b10) && (offset != 2'b00));
    return bad_f3 || misaligned;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane steering for the load/store unit.
//   funct3     : access size (bits [1:0]) and unsigned flag (bit 2)
//   offset     : byte offset inside the 32-bit word
//   rdata      : word read from the RAM
//   wdata      : store data (low byte/halfword used for SB/SH)
//   load_data  : selected lane, sign- or zero-extended
//   merge_data : rdata with the addressed byte/halfword replaced by wdata
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [31:0] shifted;
  logic        sign_ext;

  // NOTE: every output of a combinational block gets a default before any
  // branch, otherwise a path that skips the assignment infers a latch.
  always_comb begin
    shifted    = rdata >> {offset, 3'b000};
    sign_ext   = !funct3[2];
    load_data  = rdata;
    merge_data = wdata;
    case (funct3[1:0])
      2'b00: begin
        load_data  = {{24{shifted[7] & sign_ext}}, shifted[7:0]};
        merge_data = rdata;
        merge_data[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      2'b01: begin
        // Halfwords are aligned, so only offset[1] selects the lane.
        load_data  = {{16{shifted[15] & sign_ext}}, shifted[15:0]};
        merge_data = rdata;
        merge_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = rdata;
        merge_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit driving a word-wide synchronous-read data RAM.
//   CLK, RST                : clock, synchronous active-high reset
//   req_*                   : one load/store request, sampled in IDLE only
//   busy                    : access in flight, pipeline must stall
//   resp_valid/rdata/err    : one-cycle completion with formatted load data
//   daddr, MemRead, MemWrite,
//   ddata_w, ddata_r        : RAM port (read data arrives one cycle after MemRead)
// SB/SH are done as read-modify-write: read in the accept cycle, merged write
// in RMW_MERGE, response in DONE.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int data_width = 32,
  parameter int addr_width = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [data_width-1:0] req_wdata,
  output logic                  busy,
  output logic                  resp_valid,
  output logic [data_width-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [addr_width-1:0] daddr,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [data_width-1:0] ddata_w,
  input  logic [data_width-1:0] ddata_r
);

  lsu_state_t            state;
  logic [2:0]            f3_q;
  logic [addr_width+1:0] addr_q;
  logic [data_width-1:0] wdata_q;
  logic                  err_q;

  logic                  accept_err;
  logic                  is_sw;
  logic [31:0]           load_data;
  logic [31:0]           merge_data;

  // Address bits above the RAM size are dropped so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:addr_width+2];

  assign accept_err = req_illegal(req_write, req_funct3, req_addr[1:0]);
  assign is_sw      = req_write && (req_funct3 == F3_W);
  assign busy       = (state != IDLE);

  lsu_byte_lane u_lane (
    .funct3     (f3_q),
    .offset     (addr_q[1:0]),
    .rdata      (ddata_r),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            f3_q    <= req_funct3;
            addr_q  <= req_addr[addr_width+1:0];
            wdata_q <= req_wdata;
            err_q   <= accept_err;
            if (accept_err || is_sw) state <= DONE;
            else if (req_write)      state <= RMW_MERGE;
            else                     state <= LOAD_RESP;
          end
        end
        LOAD_RESP: state <= IDLE;
        RMW_MERGE: state <= DONE;
        DONE:      state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // RAM strobes and responses are decoded from the current state so the
  // accept-cycle access starts without a register delay. Everything is held
  // at zero during reset, which also kills an in-flight merge write/response.
  always_comb begin
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    daddr      = '0;
    ddata_w    = '0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    if (!RST) begin
      case (state)
        IDLE: begin
          daddr = req_addr[addr_width+1:2];
          if (req_valid && !accept_err) begin
            if (is_sw) begin
              MemWrite = 1'b1;
              ddata_w  = req_wdata;
            end else begin
              // Loads and SB/SH both start with a read.
              MemRead = 1'b1;
            end
          end
        end
        LOAD_RESP: begin
          daddr      = addr_q[addr_width+1:2];
          resp_valid = 1'b1;
          resp_rdata = load_data;
        end
        RMW_MERGE: begin
          daddr    = addr_q[addr_width+1:2];
          MemWrite = 1'b1;
          ddata_w  = merge_data;
        end
        DONE: begin
          daddr      = addr_q[addr_width+1:2];
          resp_valid = 1'b1;
          resp_err   = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a behavioural synchronous-read RAM,
// directed stimulus with hand-computed results pushed to a scoreboard, and a
// monitor that pops and compares on every resp_valid.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  daddr;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ddata_w;
  logic [31:0] ddata_r;

  load_store_unit #(.data_width(32), .addr_width(10)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .daddr      (daddr),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .ddata_w    (ddata_w),
    .ddata_r    (ddata_r)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [0:1023];
  always @(posedge CLK) begin
    if (MemWrite) mem[daddr] <= ddata_w;
    if (MemRead)  ddata_r    <= mem[daddr];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (resp_valid) begin : mon
      exp_t e;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_resp: got rdata 0x%08h err %0b, expected no response",
                 resp_rdata, resp_err);
      end else begin
        e = sb_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  task automatic expect_resp(input logic [31:0] rd, input logic err);
    exp_t e;
    e.rdata = rd;
    e.err   = err;
    sb_q.push_back(e);
  endtask

  // Called in the accept cycle; resp_valid must appear exactly lat cycles later.
  task automatic finish_req(input string name, input int lat);
    for (int c = 1; c <= lat; c++) begin
      step();
      req_valid = 1'b0;
      #3;
      check({name, " resp_valid timing"}, 32'(resp_valid), 32'(c == lat));
      check({name, " busy"}, 32'(busy), 32'd1);
    end
    step();
    check({name, " busy after resp"}, 32'(busy), 32'd0);
  endtask

  logic [2:0]  t2_f3 [4] = '{F3_B, F3_BU, F3_H, F3_HU};
  logic [31:0] t2_a  [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
  logic [31:0] t2_e  [4] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF};

  logic        t6_w  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] t6_a  [5] = '{32'h20, 32'h20, 32'h28, 32'h28, 32'h24};
  logic [31:0] t6_wd [5] = '{32'hCAFE_F00D, 32'h0, 32'h0123_4567, 32'h0, 32'h0};
  logic [31:0] t6_e  [5] = '{32'h0, 32'hCAFE_F00D, 32'h0, 32'h0123_4567, 32'h0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    ddata_r = 32'h0;
    RST     = 1'b1;
    drive(1'b0, F3_W, 32'h10, 32'h0);

    // Reset: strobes forced low even with a request present.
    step();
    #3;
    check("rst MemRead", 32'(MemRead), 32'd0);
    check("rst MemWrite", 32'(MemWrite), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst daddr", 32'(daddr), 32'd0);
    check("rst ddata_w", ddata_w, 32'd0);
    step();
    RST       = 1'b0;
    req_valid = 1'b0;
    step();

    // 1: SW then LW.
    drive(1'b1, F3_W, 32'h10, 32'hDEAD_BEEF);
    expect_resp(32'h0, 1'b0);
    #3;
    check("sw MemWrite", 32'(MemWrite), 32'd1);
    check("sw MemRead", 32'(MemRead), 32'd0);
    check("sw daddr", 32'(daddr), 32'd4);
    check("sw ddata_w", ddata_w, 32'hDEAD_BEEF);
    finish_req("sw", 1);

    drive(1'b0, F3_W, 32'h10, 32'h0);
    expect_resp(32'hDEAD_BEEF, 1'b0);
    #3;
    check("lw MemRead", 32'(MemRead), 32'd1);
    check("lw daddr", 32'(daddr), 32'd4);
    finish_req("lw", 1);

    // 2: sub-word loads.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, t2_f3[i], t2_a[i], 32'h0);
      expect_resp(t2_e[i], 1'b0);
      finish_req("subword load", 1);
    end

    // 3: SB read-modify-write with explicit cycle checks, then SH.
    drive(1'b1, F3_B, 32'h11, 32'h1234_56AA);
    expect_resp(32'h0, 1'b0);
    #3;
    check("sb MemRead T", 32'(MemRead), 32'd1);
    check("sb MemWrite T", 32'(MemWrite), 32'd0);
    check("sb daddr T", 32'(daddr), 32'd4);
    step();
    req_valid = 1'b0;
    #3;
    check("sb MemWrite T+1", 32'(MemWrite), 32'd1);
    check("sb MemRead T+1", 32'(MemRead), 32'd0);
    check("sb daddr T+1", 32'(daddr), 32'd4);
    check("sb ddata_w T+1", ddata_w, 32'hDEAD_AAEF);
    check("sb resp_valid T+1", 32'(resp_valid), 32'd0);
    step();
    #3;
    check("sb resp_valid T+2", 32'(resp_valid), 32'd1);
    step();
    check("sb busy after", 32'(busy), 32'd0);

    drive(1'b1, F3_H, 32'h12, 32'h0000_5555);
    expect_resp(32'h0, 1'b0);
    finish_req("sh", 2);
    drive(1'b0, F3_W, 32'h10, 32'h0);
    expect_resp(32'h5555_AAEF, 1'b0);
    finish_req("lw after sh", 1);

    // 4: errors.
    drive(1'b0, F3_W, 32'h12, 32'h0);
    expect_resp(32'h0, 1'b1);
    #3;
    check("lw misaligned MemRead", 32'(MemRead), 32'd0);
    check("lw misaligned MemWrite", 32'(MemWrite), 32'd0);
    finish_req("lw misaligned", 1);

    drive(1'b1, F3_H, 32'h13, 32'hFFFF_FFFF);
    expect_resp(32'h0, 1'b1);
    #3;
    check("sh misaligned MemRead", 32'(MemRead), 32'd0);
    check("sh misaligned MemWrite", 32'(MemWrite), 32'd0);
    finish_req("sh misaligned", 1);

    drive(1'b0, 3'b011, 32'h10, 32'h0);
    expect_resp(32'h0, 1'b1);
    finish_req("load f3 011", 1);

    drive(1'b0, F3_W, 32'h10, 32'h0);
    expect_resp(32'h5555_AAEF, 1'b0);
    finish_req("lw after errors", 1);

    // 5: reset during RMW_MERGE aborts the store and its response.
    drive(1'b1, F3_H, 32'h10, 32'h0000_1111);
    step();
    req_valid = 1'b0;
    RST       = 1'b1;
    #3;
    check("abort MemWrite", 32'(MemWrite), 32'd0);
    check("abort resp_valid", 32'(resp_valid), 32'd0);
    step();
    RST = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    #3;
    check("abort resp_valid after", 32'(resp_valid), 32'd0);
    step();
    drive(1'b0, F3_W, 32'h10, 32'h0);
    expect_resp(32'h5555_AAEF, 1'b0);
    finish_req("lw after abort", 1);

    // 6: req_valid held high; requests during busy are dropped.
    for (int k = 0; k < 5; k++) begin
      drive(t6_w[k], F3_W, t6_a[k], t6_wd[k]);
      expect_resp(t6_e[k], 1'b0);
      #3;
      check("stream idle busy", 32'(busy), 32'd0);
      check("stream accept strobe", 32'(MemRead | MemWrite), 32'd1);
      step();
      drive(1'b1, F3_W, 32'h24, 32'hBAD0_BAD0);
      #3;
      check("stream busy", 32'(busy), 32'd1);
      check("stream drop MemWrite", 32'(MemWrite), 32'd0);
      check("stream drop MemRead", 32'(MemRead), 32'd0);
      step();
    end
    req_valid = 1'b0;
    step();
    step();
    step();

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
